// File: rtl/ainv_trace_gen.sv
// Trace generator exercising cache address-invalidate: per address issues STORE, AINV, LOAD,
// then drains responses and parks in DONE until reset.
module ainv_trace_gen #(
  parameter int                      data_width_p   = 32,
  parameter int                      addr_width_p   = 32,
  parameter int                      src_id_width_p = 4,
  parameter int                      num_addr_p     = 16,
  parameter logic [addr_width_p-1:0] base_addr_p    = '0,
  parameter int                      stride_p       = 64
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      en_i,
  output logic                      v_o,
  input  logic                      ready_and_i,
  output logic [1:0]                opcode_o,
  output logic [addr_width_p-1:0]   addr_o,
  output logic [data_width_p-1:0]   data_o,
  output logic [src_id_width_p-1:0] src_id_o,
  input  logic                      resp_v_i,
  output logic                      done_o
);

  localparam int total_lp   = 3 * num_addr_p;
  localparam int cnt_w_lp   = $clog2(total_lp + 1);
  localparam int k_w_lp     = (num_addr_p > 1) ? $clog2(num_addr_p) : 1;
  localparam int src_max_lp = (1 << src_id_width_p) - 1;

  localparam logic [k_w_lp-1:0]         k_last_lp  = k_w_lp'(num_addr_p - 1);
  localparam logic [cnt_w_lp-1:0]       total_c_lp = cnt_w_lp'(total_lp);
  localparam logic [src_id_width_p-1:0] src_max_c  = src_id_width_p'(src_max_lp);
  localparam logic [src_id_width_p-1:0] src_one_c  = src_id_width_p'(1);

  localparam logic [1:0] op_load_lp  = 2'd0;
  localparam logic [1:0] op_store_lp = 2'd1;
  localparam logic [1:0] op_ainv_lp  = 2'd2;

  // IDLE wait en | STORE/AINV/LOAD issue for index k | DRAIN await responses | DONE terminal
  typedef enum logic [2:0] {IDLE, STORE, AINV, LOAD, DRAIN, DONE} state_e;

  state_e                    state_q, state_d;
  logic [k_w_lp-1:0]         k_q, k_d;
  logic [src_id_width_p-1:0] lsrc_q, lsrc_d;
  logic [cnt_w_lp-1:0]       issued_q, issued_d;
  logic [cnt_w_lp-1:0]       returned_q, returned_d;
  logic                      xfer;

  assign xfer = v_o & ready_and_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      k_q        <= '0;
      lsrc_q     <= src_one_c;
      issued_q   <= '0;
      returned_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      lsrc_q     <= lsrc_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    lsrc_d     = lsrc_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d    = STORE;
          k_d        = '0;
          lsrc_d     = src_one_c;
          issued_d   = '0;
          returned_d = '0;
        end
      end
      STORE: if (xfer) state_d = AINV;
      AINV:  if (xfer) state_d = LOAD;
      LOAD: begin
        if (xfer) begin
          if (k_q == k_last_lp) begin
            state_d = DRAIN;
          end else begin
            state_d = STORE;
            k_d     = k_q + k_w_lp'(1);
            // load source id cycles 1..2^w-1 so it never reads as zero
            lsrc_d  = (lsrc_q == src_max_c) ? src_one_c : lsrc_q + src_one_c;
          end
        end
      end
      DRAIN: if (returned_q == total_c_lp) state_d = DONE;
      DONE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (xfer) issued_d = issued_q + cnt_w_lp'(1);
    if (resp_v_i && (state_q != IDLE) && (state_q != DONE)) returned_d = returned_q + cnt_w_lp'(1);
  end

  always_comb begin
    logic [addr_width_p-1:0] addr_k;
    addr_k   = base_addr_p + addr_width_p'(k_q) * addr_width_p'(stride_p);
    v_o      = 1'b0;
    opcode_o = op_load_lp;
    addr_o   = '0;
    data_o   = '0;
    src_id_o = '0;
    done_o   = (state_q == DONE);
    case (state_q)
      STORE: begin
        v_o      = 1'b1;
        opcode_o = op_store_lp;
        addr_o   = addr_k;
        data_o   = data_width_p'(k_q) + data_width_p'(1);
      end
      AINV: begin
        v_o      = 1'b1;
        opcode_o = op_ainv_lp;
        addr_o   = addr_k;
      end
      LOAD: begin
        v_o      = 1'b1;
        opcode_o = op_load_lp;
        addr_o   = addr_k;
        src_id_o = lsrc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && (returned_q > issued_q))
      $fatal(1, "ainv_trace_gen: returned count exceeds issued count");
  end

endmodule

// File: tb/tb_ainv_trace_gen.sv
// Directed bench for ainv_trace_gen: default-ish instance (4 addresses) with a small cache model,
// plus a narrow source-id instance (2-bit ids, 5 addresses).
module tb_ainv_trace_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_en, a_ready, a_resp_v, a_v, a_done;
  logic [1:0]  a_op;
  logic [31:0] a_addr, a_data;
  logic [3:0]  a_src;
  logic        b_en, b_ready, b_resp_v, b_v, b_done;
  logic [1:0]  b_op;
  logic [31:0] b_addr, b_data;
  logic [1:0]  b_src;

  int errs   = 0;
  int checks = 0;

  ainv_trace_gen #(.num_addr_p(4)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(a_en), .v_o(a_v), .ready_and_i(a_ready),
    .opcode_o(a_op), .addr_o(a_addr), .data_o(a_data), .src_id_o(a_src),
    .resp_v_i(a_resp_v), .done_o(a_done)
  );

  ainv_trace_gen #(.num_addr_p(5), .src_id_width_p(2)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(b_en), .v_o(b_v), .ready_and_i(b_ready),
    .opcode_o(b_op), .addr_o(b_addr), .data_o(b_data), .src_id_o(b_src),
    .resp_v_i(b_resp_v), .done_o(b_done)
  );

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [3:0]  src;
    logic [31:0] data;
  } rsp_t;

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // mode 0: always ready, response 2 cycles later; 1: random ready; 2: response 1 cycle later
  task automatic run_a(input int mode, input string nm);
    rsp_t        q[$];
    rsp_t        r;
    logic [31:0] mem[4];
    logic [69:0] cur, p_out, exp;
    logic [1:0]  e_op;
    int          cyc, nx, ret, last_c, i, ph, dly;
    bit          p_stall, fin;
    cyc = 0; nx = 0; ret = 0; last_c = -100; p_stall = 0; fin = 0; p_out = '0;
    dly = (mode == 2) ? 1 : 2;
    foreach (mem[j]) mem[j] = 32'd0;
    a_resp_v = 1'b0;
    @(negedge clk);
    a_en = 1'b1;
    while (!fin) begin
      @(negedge clk);
      a_en = 1'b0;
      cyc++;
      cur = {a_op, a_addr, a_data, a_src};
      if (p_stall) chk({nm, "_stall_hold"}, 96'(cur), 96'(p_out));
      chk({nm, "_v"}, 96'(a_v), 96'(nx < 12));
      chk({nm, "_done"}, 96'(a_done), 96'(ret == 12 && cyc >= last_c + 2));
      if (a_done) fin = 1;
      if (cyc > 400) begin
        chk({nm, "_timeout"}, 96'(0), 96'(1));
        fin = 1;
      end
      a_ready  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      a_resp_v = 1'b0;
      if (q.size() > 0 && q[0].due <= cyc) begin
        r = q.pop_front();
        a_resp_v = 1'b1;
        ret++;
        last_c = cyc;
        if (r.src != 4'd0) chk({nm, "_ainv_load_data"}, 96'(r.data), 96'(0));
      end
      if (a_v && a_ready) begin
        i    = nx / 3;
        ph   = nx % 3;
        e_op = (ph == 0) ? 2'd1 : ((ph == 1) ? 2'd2 : 2'd0);
        exp  = {e_op, 32'(64 * i), (ph == 0) ? 32'(i + 1) : 32'd0, (ph == 2) ? 4'(i + 1) : 4'd0};
        chk({nm, "_req"}, 96'(cur), 96'(exp));
        r.due  = cyc + dly;
        r.src  = a_src;
        r.data = 32'd0;
        case (a_op)
          2'd1: mem[a_addr[7:6]] = a_data;
          2'd2: mem[a_addr[7:6]] = 32'd0;
          default: r.data = mem[a_addr[7:6]];
        endcase
        q.push_back(r);
        nx++;
      end
      p_stall = a_v && !a_ready;
      p_out   = cur;
    end
    a_resp_v = 1'b0;
    chk({nm, "_issued"}, 96'(nx), 96'(12));
    chk({nm, "_returned"}, 96'(ret), 96'(12));
    chk({nm, "_done_end"}, 96'(a_done), 96'(1));
  endtask

  initial begin
    int   exp_src[5];
    int   nx, nld, cyc;
    logic prev;
    exp_src = '{1, 2, 3, 1, 2};
    a_en = 0; a_ready = 0; a_resp_v = 0;
    b_en = 0; b_ready = 0; b_resp_v = 0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_v", 96'(a_v), 96'(0));
    chk("reset_done", 96'(a_done), 96'(0));
    chk("reset_outs", 96'({a_op, a_addr, a_data, a_src}), 96'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_effect", 96'({a_v, a_done, a_op, a_addr}), 96'(0));

    run_a(0, "basic");
    // DONE is terminal: responses and en are ignored there
    a_resp_v = 1'b1; a_en = 1'b1;
    repeat (3) @(negedge clk);
    a_resp_v = 1'b0; a_en = 1'b0;
    @(negedge clk);
    chk("done_hold", 96'({a_done, a_v}), 96'({1'b1, 1'b0}));

    do_reset();
    run_a(1, "stall");
    do_reset();
    run_a(2, "coinc");

    do_reset();
    @(negedge clk);
    a_en = 1'b1; a_ready = 1'b1;
    @(negedge clk);
    a_en = 1'b0;
    chk("rst_pre_store", 96'({a_v, a_op}), 96'({1'b1, 2'd1}));
    @(negedge clk);
    a_ready = 1'b0;
    chk("rst_pre_ainv", 96'({a_v, a_op}), 96'({1'b1, 2'd2}));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_v", 96'(a_v), 96'(0));
    chk("rst_async_outs", 96'({a_op, a_addr, a_data, a_src, a_done}), 96'(0));
    @(negedge clk);
    rst_n = 1'b1;
    a_resp_v = 1'b1;
    repeat (3) @(negedge clk);
    a_resp_v = 1'b0;
    chk("rst_idle_quiet", 96'({a_v, a_done}), 96'(0));
    run_a(0, "restart");

    nx = 0; nld = 0; cyc = 0; prev = 1'b0;
    @(negedge clk);
    b_en = 1'b1; b_ready = 1'b1;
    while (!b_done && cyc < 200) begin
      @(negedge clk);
      b_en = 1'b0;
      cyc++;
      b_resp_v = prev;
      prev = b_v && b_ready;
      if (prev) begin
        if (b_op == 2'd0) begin
          if (nld < 5) begin
            chk("b_load_src", 96'(b_src), 96'(exp_src[nld]));
            chk("b_load_addr", 96'(b_addr), 96'(64 * nld));
          end
          nld++;
        end
        nx++;
      end
    end
    b_resp_v = 1'b0;
    chk("b_issued", 96'(nx), 96'(15));
    chk("b_loads", 96'(nld), 96'(5));
    chk("b_done", 96'(b_done), 96'(1));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
